// File: rtl/mandel_pkg.sv
// -----------------------------------------------------------------------------
// mandel_pkg
// Shared definitions for the Mandelbrot pixel generator slice:
//   FX_W / FX_FRAC : signed 4.23 fixed-point format of every coordinate
//   fx_t           : coordinate type
//   state_e        : frame sequencer state encoding
//   fx_shl         : arithmetic left shift used to scale the x step per lane
// -----------------------------------------------------------------------------
package mandel_pkg;

  localparam int FX_W    = 27;
  localparam int FX_FRAC = 23;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Multiply a coordinate step by 2**sh, keeping 27-bit two's-complement wrap.
  function automatic fx_t fx_shl(input fx_t v, input int unsigned sh);
    return v <<< sh;
  endfunction

endpackage

// File: rtl/mandel_pixel_gen_if.sv
// -----------------------------------------------------------------------------
// mandel_pixel_gen_if
// Coordinate stream from the pixel generator to a Mandelbrot iterator.
//   out_c_r, out_c_i : signed 4.23 coordinate of the pixel
//   out_px, out_py   : pixel tag (column, row)
//   out_val          : generator has a pixel on the bus
//   out_rdy          : iterator accepts it (transfer when out_val & out_rdy)
// Modports: master = generator side, slave = iterator side.
// PX_W/PY_W must equal $clog2(H_RES)/$clog2(V_RES) of the generator.
// -----------------------------------------------------------------------------
interface mandel_pixel_gen_if #(
  parameter int PX_W = 10,
  parameter int PY_W = 9
);
  import mandel_pkg::*;

  fx_t             out_c_r;
  fx_t             out_c_i;
  logic [PX_W-1:0] out_px;
  logic [PY_W-1:0] out_py;
  logic            out_val;
  logic            out_rdy;

  modport master (
    output out_c_r, out_c_i, out_px, out_py, out_val,
    input  out_rdy
  );

  modport slave (
    input  out_c_r, out_c_i, out_px, out_py, out_val,
    output out_rdy
  );

endinterface

// File: rtl/mandel_axis_step.sv
// -----------------------------------------------------------------------------
// mandel_axis_step
// One raster axis: a pixel counter paired with a coordinate accumulator.
//   clk, reset          : clock, synchronous active-high reset (clears both)
//   reload, reload_cnt,
//   reload_acc          : frame start load (highest priority)
//   wrap, wrap_cnt,
//   wrap_acc            : row-start load
//   step, step_acc      : cnt += CNT_INC, acc += step_acc
//   cnt, acc            : registered counter and coordinate
// All coordinate sums wrap in 27-bit two's complement.
// -----------------------------------------------------------------------------
module mandel_axis_step
  import mandel_pkg::*;
#(
  parameter int CNT_W   = 10,
  parameter int CNT_INC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reload,
  input  logic [CNT_W-1:0] reload_cnt,
  input  fx_t              reload_acc,
  input  logic             wrap,
  input  logic [CNT_W-1:0] wrap_cnt,
  input  fx_t              wrap_acc,
  input  logic             step,
  input  fx_t              step_acc,
  output logic [CNT_W-1:0] cnt,
  output fx_t              acc
);

  localparam logic [CNT_W-1:0] INC_V = CNT_W'(CNT_INC);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  fx_t              acc_d, acc_q;

  // Next counter/accumulator value: reload beats wrap beats step.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (reload) begin
      cnt_d = reload_cnt;
      acc_d = reload_acc;
    end else if (wrap) begin
      cnt_d = wrap_cnt;
      acc_d = wrap_acc;
    end else if (step) begin
      cnt_d = cnt_q + INC_V;
      acc_d = acc_q + step_acc;
    end else begin
      cnt_d = cnt_q;
      acc_d = acc_q;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign cnt = cnt_q;
  assign acc = acc_q;

endmodule

// File: rtl/mandel_pixel_gen.sv
// -----------------------------------------------------------------------------
// mandel_pixel_gen
// Walks a H_RES x V_RES frame in raster order and streams each pixel's
// complex coordinate (c_r, c_i) plus its (px, py) tag to an iterator.
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a frame (only looked at in IDLE)
//   cfg_x0, cfg_y0    : top-left c_r / c_i, signed 4.23
//   cfg_dx, cfg_dy    : per-pixel steps; c_i decreases going down
//   pix (master)      : out_c_r/out_c_i/out_px/out_py with out_val/out_rdy
//   busy              : high outside IDLE
//   frame_done        : one-cycle pulse after the last pixel transfers
// Optional build macro PIXGEN_INTERLEAVE_EN: the generator becomes lane
// LANE_ID of N_LANES interleaved lanes, emitting px = LANE_ID + k*N_LANES.
// -----------------------------------------------------------------------------
module mandel_pixel_gen
  import mandel_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
`ifdef PIXGEN_INTERLEAVE_EN
  , parameter int N_LANES = 1
  , parameter int LANE_ID = 0
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  fx_t                      cfg_x0,
  input  fx_t                      cfg_y0,
  input  fx_t                      cfg_dx,
  input  fx_t                      cfg_dy,
  mandel_pixel_gen_if.master       pix,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PX_W = $clog2(H_RES);
  localparam int PY_W = $clog2(V_RES);

`ifdef PIXGEN_INTERLEAVE_EN
  localparam int STRIDE  = N_LANES;
  localparam int LANE_SH = $clog2(N_LANES);
  localparam int ROW_PX0 = LANE_ID;
  localparam int PC_W    = (LANE_ID > 1) ? $clog2(LANE_ID) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(LANE_ID - 1);
`else
  localparam int STRIDE  = 1;
  localparam int LANE_SH = 0;
  localparam int ROW_PX0 = 0;
`endif

  // Row-wrap compare is done one bit wider so px+STRIDE cannot overflow.
  localparam logic [PX_W:0]   STRIDE_V  = (PX_W+1)'(STRIDE);
  localparam logic [PX_W:0]   H_RES_V   = (PX_W+1)'(H_RES);
  localparam logic [PX_W-1:0] ROW_PX0_V = PX_W'(ROW_PX0);
  localparam logic [PY_W-1:0] LAST_PY   = PY_W'(V_RES - 1);

  state_e state_d, state_q;
  fx_t    step_x_d, step_x_q;     // dx scaled by the lane count
  fx_t    neg_dy_d, neg_dy_q;     // -dy, so the y axis only ever adds
  fx_t    row_start_d, row_start_q; // c_r of the first pixel of each row

`ifdef PIXGEN_INTERLEAVE_EN
  fx_t             dx_d, dx_q;
  logic [PC_W-1:0] prime_cnt_d, prime_cnt_q;
`endif

  logic            x_reload, x_wrap, x_step;
  logic            y_reload, y_step;
  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;
  fx_t             c_r, c_i;
  logic            xfer, row_end, last_row;

  assign xfer     = (state_q == ST_EMIT) && pix.out_rdy;
  assign row_end  = ({1'b0, px} + STRIDE_V) >= H_RES_V;
  assign last_row = (py == LAST_PY);

  // Frame sequencer: next state, configuration latch and axis controls.
  always_comb begin
    state_d     = state_q;
    step_x_d    = step_x_q;
    neg_dy_d    = neg_dy_q;
    row_start_d = row_start_q;
    x_reload    = 1'b0;
    x_wrap      = 1'b0;
    x_step      = 1'b0;
    y_reload    = 1'b0;
    y_step      = 1'b0;
`ifdef PIXGEN_INTERLEAVE_EN
    dx_d        = dx_q;
    prime_cnt_d = prime_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_x_d    = fx_shl(cfg_dx, LANE_SH);
          neg_dy_d    = -cfg_dy;
          row_start_d = cfg_x0;
          x_reload    = 1'b1;
          y_reload    = 1'b1;
`ifdef PIXGEN_INTERLEAVE_EN
          dx_d        = cfg_dx;
          prime_cnt_d = '0;
          state_d     = (LANE_ID == 0) ? ST_EMIT : ST_PRIME;
`else
          state_d     = ST_EMIT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef PIXGEN_INTERLEAVE_EN
      // Advance the row start by one dx per cycle; the x axis follows it
      // through wrap so it already holds the lane's first c_r on entry to EMIT.
      ST_PRIME: begin
        row_start_d = row_start_q + dx_q;
        x_wrap      = 1'b1;
        prime_cnt_d = prime_cnt_q + 1'b1;
        if (prime_cnt_q == PC_LAST) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_PRIME;
        end
      end
`endif
      ST_EMIT: begin
        if (xfer) begin
          if (row_end) begin
            x_wrap = 1'b1;
            y_step = 1'b1;
            if (last_row) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_EMIT;
            end
          end else begin
            x_step = 1'b1;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and latched-configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_x_q    <= '0;
      neg_dy_q    <= '0;
      row_start_q <= '0;
`ifdef PIXGEN_INTERLEAVE_EN
      dx_q        <= '0;
      prime_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      step_x_q    <= step_x_d;
      neg_dy_q    <= neg_dy_d;
      row_start_q <= row_start_d;
`ifdef PIXGEN_INTERLEAVE_EN
      dx_q        <= dx_d;
      prime_cnt_q <= prime_cnt_d;
`endif
    end
  end

  mandel_axis_step #(
    .CNT_W   (PX_W),
    .CNT_INC (STRIDE)
  ) u_axis_x (
    .clk        (clk),
    .reset      (reset),
    .reload     (x_reload),
    .reload_cnt ({PX_W{1'b0}}),
    .reload_acc (cfg_x0),
    .wrap       (x_wrap),
    .wrap_cnt   (ROW_PX0_V),
    .wrap_acc   (row_start_d),
    .step       (x_step),
    .step_acc   (step_x_q),
    .cnt        (px),
    .acc        (c_r)
  );

  mandel_axis_step #(
    .CNT_W   (PY_W),
    .CNT_INC (1)
  ) u_axis_y (
    .clk        (clk),
    .reset      (reset),
    .reload     (y_reload),
    .reload_cnt ({PY_W{1'b0}}),
    .reload_acc (cfg_y0),
    .wrap       (1'b0),
    .wrap_cnt   ({PY_W{1'b0}}),
    .wrap_acc   ({FX_W{1'b0}}),
    .step       (y_step),
    .step_acc   (neg_dy_q),
    .cnt        (py),
    .acc        (c_i)
  );

  assign pix.out_c_r = c_r;
  assign pix.out_c_i = c_i;
  assign pix.out_px  = px;
  assign pix.out_py  = py;
  assign pix.out_val = (state_q == ST_EMIT);
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mandel_pixel_gen.sv
// -----------------------------------------------------------------------------
// tb_mandel_pixel_gen
// Directed bench for mandel_pixel_gen on a 4x3 frame. With the build macro
// PIXGEN_INTERLEAVE_EN defined the DUT is built as lane 1 of 2.
// -----------------------------------------------------------------------------
module tb_mandel_pixel_gen;
  import mandel_pkg::*;

  localparam int H = 4;
  localparam int V = 3;
`ifdef PIXGEN_INTERLEAVE_EN
  localparam int LANES = 2;
  localparam int LANE  = 1;
`else
  localparam int LANES = 1;
  localparam int LANE  = 0;
`endif
  localparam int PER_ROW = H / LANES;
  localparam int NPIX    = PER_ROW * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, busy, frame_done;
  fx_t  cfg_x0, cfg_y0, cfg_dx, cfg_dy;

  mandel_pixel_gen_if #(.PX_W(2), .PY_W(2)) pif ();

`ifdef PIXGEN_INTERLEAVE_EN
  mandel_pixel_gen #(.H_RES(H), .V_RES(V), .N_LANES(LANES), .LANE_ID(LANE)) dut (
`else
  mandel_pixel_gen #(.H_RES(H), .V_RES(V)) dut (
`endif
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_dx     (cfg_dx),
    .cfg_dy     (cfg_dy),
    .pix        (pif),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  fx_t         m_x0, m_y0, m_dx, m_dy;   // configuration the frame was started with
  logic [26:0] row0_cr [H];
  logic [26:0] last_cr, last_ci, last_px, last_py;

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and follow it transfer by transfer against the raster model.
  // stop_after > 0 returns right after that many transfers.
  task automatic run_frame(input bit rnd, input bit disturb, input int stop_after);
    int          n, cyc, fd_early, target, ex_px, ex_py;
    bit          stalled, dist_done;
    logic [26:0] s_cr, s_ci, s_px, s_py;
    fx_t         e_cr, e_ci;
    n = 0; cyc = 0; fd_early = 0; stalled = 1'b0; dist_done = 1'b0;
    s_cr = '0; s_ci = '0; s_px = '0; s_py = '0;
    target = (stop_after > 0) ? stop_after : NPIX;
    pif.out_rdy = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("first_val", 27'(pif.out_val), 27'(LANE == 0));
    while (n < target && cyc < 400) begin
      if (frame_done) fd_early++;
      if (stalled) begin
        check("hold_val", 27'(pif.out_val), 27'd1);
        check("hold_cr", pif.out_c_r, s_cr);
        check("hold_ci", pif.out_c_i, s_ci);
        check("hold_px", 27'(pif.out_px), s_px);
        check("hold_py", 27'(pif.out_py), s_py);
      end
      if (disturb && n == 3 && !dist_done) begin
        start = 1'b1;
        cfg_x0 = 27'h0123456;
        dist_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      pif.out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pif.out_val && pif.out_rdy) begin
        ex_px = LANE + (n % PER_ROW) * LANES;
        ex_py = n / PER_ROW;
        e_cr  = m_x0 + fx_t'(ex_px) * m_dx;
        e_ci  = m_y0 - fx_t'(ex_py) * m_dy;
        check("px", 27'(pif.out_px), 27'(ex_px));
        check("py", 27'(pif.out_py), 27'(ex_py));
        check("c_r", pif.out_c_r, e_cr);
        check("c_i", pif.out_c_i, e_ci);
        if (ex_py == 0) row0_cr[ex_px] = pif.out_c_r;
        last_cr = pif.out_c_r;
        last_ci = pif.out_c_i;
        last_px = 27'(pif.out_px);
        last_py = 27'(pif.out_py);
        n++;
      end
      stalled = pif.out_val && !pif.out_rdy;
      s_cr = pif.out_c_r;
      s_ci = pif.out_c_i;
      s_px = 27'(pif.out_px);
      s_py = 27'(pif.out_py);
      step();
      cyc++;
    end
    start = 1'b0;
    check("xfer_count", 27'(n), 27'(target));
    check("no_early_done", 27'(fd_early), 27'd0);
    if (stop_after == 0) begin
      check("done_pulse", 27'(frame_done), 27'd1);
      check("done_noval", 27'(pif.out_val), 27'd0);
      pif.out_rdy = 1'b1;
      step();
      check("done_once", 27'(frame_done), 27'd0);
      check("idle_busy", 27'(busy), 27'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pif.out_rdy = 1'b0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_dx = '0; cfg_dy = '0;
    last_cr = '0; last_ci = '0; last_px = '0; last_py = '0;
    for (int i = 0; i < H; i++) row0_cr[i] = '0;
    step();
    step();
    check("rst_val", 27'(pif.out_val), 27'd0);
    check("rst_busy", 27'(busy), 27'd0);
    check("rst_done", 27'(frame_done), 27'd0);
    check("rst_px", 27'(pif.out_px), 27'd0);
    check("rst_py", 27'(pif.out_py), 27'd0);
    check("rst_cr", pif.out_c_r, 27'd0);
    check("rst_ci", pif.out_c_i, 27'd0);

    // Reset wins over start in the same cycle.
    m_x0 = 27'h7000000; m_y0 = 27'h0800000; m_dx = 27'h0200000; m_dy = 27'h0200000;
    cfg_x0 = m_x0; cfg_y0 = m_y0; cfg_dx = m_dx; cfg_dy = m_dy;
    start = 1'b1;
    step();
    check("rst_prio_busy", 27'(busy), 27'd0);
    check("rst_prio_cr", pif.out_c_r, 27'd0);
    start = 1'b0; reset = 1'b0;
    step();

    // Basic 4x3 frame with the iterator always ready.
    run_frame(1'b0, 1'b0, 0);
    check("last_px", last_px, 27'd3);
    check("last_py", last_py, 27'd2);
    check("last_cr_m1p25", last_cr, 27'h7600000);
    check("last_ci_0p5", last_ci, 27'h0400000);
    check("px1_cr_m1p75", row0_cr[1], 27'h7200000);

    // Pseudo-random back-pressure.
    run_frame(1'b1, 1'b0, 0);

    // Reset after the fifth transfer, then a full replay.
    run_frame(1'b0, 1'b0, 5);
    reset = 1'b1;
    step();
    check("midrst_val", 27'(pif.out_val), 27'd0);
    check("midrst_busy", 27'(busy), 27'd0);
    check("midrst_px", 27'(pif.out_px), 27'd0);
    check("midrst_cr", pif.out_c_r, 27'd0);
    reset = 1'b0;
    step();
    run_frame(1'b0, 1'b0, 0);

    // Start pulse and cfg_x0 change mid-frame are ignored.
    run_frame(1'b0, 1'b1, 0);
    cfg_x0 = m_x0;

    // Coordinate wrap-around at the top of the 4.23 range.
    m_x0 = 27'h3FFFFFF; m_dx = 27'h0000001;
    cfg_x0 = m_x0; cfg_dx = m_dx;
    run_frame(1'b0, 1'b0, 0);
    check("wrap_cr", row0_cr[1], 27'h4000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
